// File: rtl/dx_latch.sv
// dx_latch: decode-to-execute pipeline register with flush, execute back-pressure and load-use bubbles.
// Define DX_HAZARD_DETECT_EN to enable load-use detection, bubble insertion and bubble_count.
module dx_latch #(
    parameter logic [31:0] NOP   = 32'h0000_0000,
    parameter int          CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      d_instruction,
    input  logic [31:0]      d_pc,
    input  logic [31:0]      d_reg_a,
    input  logic [31:0]      d_reg_b,
    input  logic             d_valid,
    input  logic             ex_stall,
    input  logic             flush,
    output logic [31:0]      x_instruction,
    output logic [31:0]      x_pc,
    output logic [31:0]      x_reg_a,
    output logic [31:0]      x_reg_b,
    output logic             x_valid,
    output logic             fd_stall,
    output logic [CNT_W-1:0] bubble_count
);
    typedef enum logic [1:0] {UPD_LOAD, UPD_BUBBLE, UPD_HOLD, UPD_FLUSH} upd_e;

    upd_e        upd_s;
    logic        hazard_s;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] reg_a_q, reg_a_d;
    logic [31:0] reg_b_q, reg_b_d;
    logic        valid_q, valid_d;

`ifdef DX_HAZARD_DETECT_EN
    localparam logic [4:0] OP_LW = 5'b01000;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // fields = instruction[31:12]: opcode, rd, rs, rt; true if the instruction reads register r
    function automatic logic reads_reg(input logic [19:0] fields, input logic [4:0] r);
        logic [4:0] op;
        logic [4:0] rd;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       rs_used;
        logic       rt_used;
        logic       rd_used;
        op = fields[19:15];
        rd = fields[14:10];
        rs = fields[9:5];
        rt = fields[4:0];
        case (op)
            5'b00000, 5'b00101, 5'b00111, 5'b01000, 5'b00010, 5'b00110: rs_used = 1'b1;
            default:                                                   rs_used = 1'b0;
        endcase
        rt_used = (op == 5'b00000);
        case (op)
            5'b00111, 5'b00010, 5'b00110, 5'b00100: rd_used = 1'b1;
            default:                                rd_used = 1'b0;
        endcase
        reads_reg = (rs_used && (rs == r)) || (rt_used && (rt == r)) || (rd_used && (rd == r));
    endfunction

    // Load-use hazard: a valid lw with nonzero rd sits in x and decode reads that rd
    always_comb begin
        hazard_s = 1'b0;
        if (valid_q && (instr_q[31:27] == OP_LW) && (instr_q[26:22] != 5'd0) && d_valid) begin
            hazard_s = reads_reg(d_instruction[31:12], instr_q[26:22]);
        end else begin
            hazard_s = 1'b0;
        end
    end

    // Saturating bubble counter: only a real bubble insertion advances it
    always_comb begin
        cnt_d = cnt_q;
        if ((upd_s == UPD_BUBBLE) && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Bubble counter register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bubble_count = cnt_q;
`else
    assign hazard_s     = 1'b0;
    assign bubble_count = {CNT_W{1'b0}};
`endif

    // Update selection: flush beats ex_stall, which beats a hazard bubble
    always_comb begin
        upd_s = UPD_LOAD;
        if (flush) begin
            upd_s = UPD_FLUSH;
        end else if (ex_stall) begin
            upd_s = UPD_HOLD;
        end else if (hazard_s) begin
            upd_s = UPD_BUBBLE;
        end else begin
            upd_s = UPD_LOAD;
        end
    end

    // Next-state of the latched slot
    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        reg_a_d = reg_a_q;
        reg_b_d = reg_b_q;
        valid_d = valid_q;
        case (upd_s)
            UPD_FLUSH, UPD_BUBBLE: begin
                instr_d = NOP;
                pc_d    = 32'h0000_0000;
                reg_a_d = 32'h0000_0000;
                reg_b_d = 32'h0000_0000;
                valid_d = 1'b0;
            end
            UPD_LOAD: begin
                instr_d = d_instruction;
                pc_d    = d_pc;
                reg_a_d = d_reg_a;
                reg_b_d = d_reg_b;
                valid_d = d_valid;
            end
            UPD_HOLD: begin
                instr_d = instr_q;
                pc_d    = pc_q;
                reg_a_d = reg_a_q;
                reg_b_d = reg_b_q;
                valid_d = valid_q;
            end
            default: begin
                instr_d = instr_q;
                pc_d    = pc_q;
                reg_a_d = reg_a_q;
                reg_b_d = reg_b_q;
                valid_d = valid_q;
            end
        endcase
    end

    // Pipeline register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            instr_q <= NOP;
            pc_q    <= 32'h0000_0000;
            reg_a_q <= 32'h0000_0000;
            reg_b_q <= 32'h0000_0000;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            reg_a_q <= reg_a_d;
            reg_b_q <= reg_b_d;
            valid_q <= valid_d;
        end
    end

    assign x_instruction = instr_q;
    assign x_pc          = pc_q;
    assign x_reg_a       = reg_a_q;
    assign x_reg_b       = reg_b_q;
    assign x_valid       = valid_q;
    assign fd_stall      = ~flush & (ex_stall | hazard_s);
endmodule

// File: tb/tb_dx_latch.sv
// Self-checking bench for dx_latch: directed literal checks plus randomized traffic against a behavioural model.
module tb_dx_latch;
    localparam int          CNT_W   = 4;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;
    localparam logic [31:0] NOP     = 32'h0000_0000;
    localparam logic [31:0] LW_R3   = 32'h40C0_0000;
    localparam logic [31:0] LW_R0   = 32'h4000_0000;
    localparam logic [31:0] ADD_R3  = 32'h0006_0000;
    localparam logic [31:0] ADD_R0  = 32'h0000_0001;
    localparam logic [31:0] ADDI    = 32'h2842_0005;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [31:0]      d_instruction = 32'h0, d_pc = 32'h0, d_reg_a = 32'h0, d_reg_b = 32'h0;
    logic             d_valid = 1'b0, ex_stall = 1'b0, flush = 1'b0;
    logic [31:0]      x_instruction, x_pc, x_reg_a, x_reg_b;
    logic             x_valid, fd_stall;
    logic [CNT_W-1:0] bubble_count;

    int n_checks = 0;
    int n_err    = 0;

    // Behavioural model of the latched slot
    logic [31:0] m_instr = NOP, m_pc = 32'h0, m_a = 32'h0, m_b = 32'h0;
    logic        m_valid = 1'b0;
    int          m_cnt   = 0;

    dx_latch #(.NOP(NOP), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset),
        .d_instruction(d_instruction), .d_pc(d_pc), .d_reg_a(d_reg_a), .d_reg_b(d_reg_b),
        .d_valid(d_valid), .ex_stall(ex_stall), .flush(flush),
        .x_instruction(x_instruction), .x_pc(x_pc), .x_reg_a(x_reg_a), .x_reg_b(x_reg_b),
        .x_valid(x_valid), .fd_stall(fd_stall), .bubble_count(bubble_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Set of registers an instruction reads, as a bitmask over r0..r31
    function automatic logic [31:0] read_mask(input logic [31:0] ins);
        logic [31:0] m;
        int op;
        m  = 32'h0;
        op = int'(ins[31:27]);
        if (op == 0 || op == 5 || op == 7 || op == 8 || op == 2 || op == 6) m[ins[21:17]] = 1'b1;
        if (op == 0) m[ins[16:12]] = 1'b1;
        if (op == 7 || op == 2 || op == 6 || op == 4) m[ins[26:22]] = 1'b1;
        return m;
    endfunction

    function automatic logic m_hazard();
`ifdef DX_HAZARD_DETECT_EN
        logic [31:0] m;
        int rd;
        m  = read_mask(d_instruction);
        rd = int'(m_instr[26:22]);
        return m_valid && (m_instr[31:27] == 5'd8) && (rd != 0) && d_valid && m[rd];
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_instr = NOP; m_pc = 32'h0; m_a = 32'h0; m_b = 32'h0; m_valid = 1'b0; m_cnt = 0;
    endtask

    // Advance one clock edge, updating the model from the pre-edge inputs
    task automatic cycle();
        logic [31:0] ni, np, na, nb;
        logic        nv;
        int          nc;
        ni = m_instr; np = m_pc; na = m_a; nb = m_b; nv = m_valid; nc = m_cnt;
        if (reset) begin
            ni = NOP; np = 0; na = 0; nb = 0; nv = 0; nc = 0;
        end else if (flush) begin
            ni = NOP; np = 0; na = 0; nb = 0; nv = 0;
        end else if (ex_stall) begin
            nv = m_valid;
        end else if (m_hazard()) begin
            ni = NOP; np = 0; na = 0; nb = 0; nv = 0;
            nc = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
        end else begin
            ni = d_instruction; np = d_pc; na = d_reg_a; nb = d_reg_b; nv = d_valid;
        end
        @(posedge clock);
        m_instr = ni; m_pc = np; m_a = na; m_b = nb; m_valid = nv; m_cnt = nc;
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic v, input logic st, input logic fl);
        d_instruction = ins; d_pc = $urandom; d_reg_a = $urandom; d_reg_b = $urandom;
        d_valid = v; ex_stall = st; flush = fl;
    endtask

    // Compare process: every falling edge, DUT against the model
    always @(negedge clock) begin
        chk("x_instruction", x_instruction, m_instr);
        chk("x_pc", x_pc, m_pc);
        chk("x_reg_a", x_reg_a, m_a);
        chk("x_reg_b", x_reg_b, m_b);
        chk("x_valid", {31'h0, x_valid}, {31'h0, m_valid});
        chk("bubble_count", {28'h0, bubble_count}, 32'(m_cnt));
        chk("fd_stall", {31'h0, fd_stall}, {31'h0, (~flush & (ex_stall | m_hazard()))});
    end

    initial begin
        logic [31:0] held;
        int          ops[10];
        ops = '{0, 2, 4, 5, 6, 7, 8, 8, 8, 31};
        model_reset();
        @(posedge clock); #1;
        chk("reset_instr", x_instruction, NOP);
        chk("reset_valid", {31'h0, x_valid}, 32'h0);
        chk("reset_cnt", {28'h0, bubble_count}, 32'h0);
        reset = 1'b0;

        // Load-use: lw r3 followed by add reading r3
        drive(LW_R3, 1'b1, 1'b0, 1'b0); cycle();
        chk("lw_loaded", x_instruction, LW_R3);
        drive(ADD_R3, 1'b1, 1'b0, 1'b0); #1;
`ifdef DX_HAZARD_DETECT_EN
        chk("hz_fd_stall", {31'h0, fd_stall}, 32'h1);
        cycle();
        chk("hz_bubble_instr", x_instruction, NOP);
        chk("hz_bubble_valid", {31'h0, x_valid}, 32'h0);
        chk("hz_cnt", {28'h0, bubble_count}, 32'h1);
        #1;
        chk("hz_after_fd", {31'h0, fd_stall}, 32'h0);
        cycle();
        chk("hz_add_loaded", x_instruction, ADD_R3);
`else
        chk("nohz_fd_stall", {31'h0, fd_stall}, 32'h0);
        cycle();
        chk("nohz_add_loaded", x_instruction, ADD_R3);
        chk("nohz_cnt", {28'h0, bubble_count}, 32'h0);
`endif

        // lw with rd=0 never stalls
        drive(LW_R0, 1'b1, 1'b0, 1'b0); cycle();
        drive(ADD_R0, 1'b1, 1'b0, 1'b0); #1;
        chk("r0_fd_stall", {31'h0, fd_stall}, 32'h0);
        cycle();
        chk("r0_add_loaded", x_instruction, ADD_R0);

        // ex_stall holds for three edges, then loads current decode
        held = ADD_R0;
        for (int i = 0; i < 3; i++) begin
            drive(32'h2800_0000 + 32'(i), 1'b1, 1'b1, 1'b0); #1;
            chk("stall_fd", {31'h0, fd_stall}, 32'h1);
            cycle();
            chk("stall_hold", x_instruction, held);
        end
        drive(ADDI, 1'b1, 1'b0, 1'b0); cycle();
        chk("stall_release", x_instruction, ADDI);

        // flush together with hazard and ex_stall
        drive(LW_R3, 1'b1, 1'b0, 1'b0); cycle();
        drive(ADD_R3, 1'b1, 1'b1, 1'b1); #1;
        chk("flush_fd", {31'h0, fd_stall}, 32'h0);
        cycle();
        chk("flush_valid", {31'h0, x_valid}, 32'h0);
        chk("flush_instr", x_instruction, NOP);
`ifdef DX_HAZARD_DETECT_EN
        chk("flush_cnt", {28'h0, bubble_count}, 32'h1);
`else
        chk("flush_cnt", {28'h0, bubble_count}, 32'h0);
`endif

        // Asynchronous reset mid-run
        drive(ADD_R0, 1'b1, 1'b0, 1'b0); cycle();
        reset = 1'b1; model_reset(); #1;
        chk("async_rst_valid", {31'h0, x_valid}, 32'h0);
        chk("async_rst_instr", x_instruction, NOP);
        @(negedge clock); #1;
        reset = 1'b0;
        drive(ADDI, 1'b1, 1'b0, 1'b0); cycle();
        chk("post_rst_instr", x_instruction, ADDI);
        chk("post_rst_valid", {31'h0, x_valid}, 32'h1);

        // Saturation of the bubble counter
        for (int i = 0; i < CNT_MAX + 2; i++) begin
            drive(LW_R3, 1'b1, 1'b0, 1'b0); cycle();
            drive(ADD_R3, 1'b1, 1'b0, 1'b0); cycle(); cycle();
        end
`ifdef DX_HAZARD_DETECT_EN
        chk("cnt_saturated", {28'h0, bubble_count}, CNT_MAX);
`else
        chk("cnt_tied_zero", {28'h0, bubble_count}, 32'h0);
`endif

        // Randomized traffic biased toward load-use pairs
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] ins;
            ins = $urandom;
            ins[31:27] = 5'(ops[$urandom_range(0, 9)]);
            ins[26:22] = 5'($urandom_range(0, 3));
            ins[21:17] = 5'($urandom_range(0, 3));
            ins[16:12] = 5'($urandom_range(0, 3));
            drive(ins, ($urandom_range(0, 99) < 85), ($urandom_range(0, 99) < 15),
                  ($urandom_range(0, 99) < 10));
            if ($urandom_range(0, 99) < 2) begin
                reset = 1'b1; model_reset();
            end else begin
                reset = 1'b0;
            end
            cycle();
        end
        reset = 1'b0;
        cycle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end
endmodule
